// File: rtl/hazard_sched_if.sv
// rtl/hazard_sched_if.sv - Decode-side hazard inputs and Exec-side control outputs of hazard_sched
interface hazard_sched_if #(
  parameter int CNT_W = 16
) ();
  logic             ValidD;
  logic [3:0]       RA1D;
  logic [3:0]       RA2D;
  logic [3:0]       RdD;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             PCSrcD;
  logic             BranchTakenE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ValidD, RA1D, RA2D, RdD, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount, FlushCount
  );

  modport slave (
    input  ValidD, RA1D, RA2D, RdD, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - pipeline hazard controller: forwarding selects, load-use stall, PC flush, perf counters
module hazard_sched #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_sched_if.slave hz
);
  // Shadow copy of the E/M/W destination info, kept in lockstep with the datapath
  logic       ve_q, ve_d;
  logic [3:0] ra1e_q, ra1e_d;
  logic [3:0] ra2e_q, ra2e_d;
  logic [3:0] rde_q, rde_d;
  logic       rwe_q, rwe_d;
  logic       mtre_q, mtre_d;
  logic       pcse_q, pcse_d;
  logic       vm_q, vm_d;
  logic [3:0] rdm_q, rdm_d;
  logic       rwm_q, rwm_d;
  logic       pcsm_q, pcsm_d;
  logic       vw_q, vw_d;
  logic [3:0] rdw_q, rdw_d;
  logic       rww_q, rww_d;
  logic       pcsw_q, pcsw_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       ld_stall;
  logic       pc_pend;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // M beats W; R15 reads the PC path, so it is never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       vm,
    input logic       rwm,
    input logic [3:0] rdm,
    input logic       vw,
    input logic       rww,
    input logic [3:0] rdw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 4'd15) begin
      if (vm && rwm && (rdm == src)) begin
        sel = 2'b10;
      end else if (vw && rww && (rdw == src)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Operand forwarding selects from the shadow scoreboard
  always_comb begin
    fwd_a = fwd_sel(ra1e_q, vm_q, rwm_q, rdm_q, vw_q, rww_q, rdw_q);
    fwd_b = fwd_sel(ra2e_q, vm_q, rwm_q, rdm_q, vw_q, rww_q, rdw_q);
  end

  // Hazard detection; a taken branch overrides the stall, and reset forces all controls low
  always_comb begin
    ld_stall = hz.ValidD & ve_q & mtre_q & ((rde_q == hz.RA1D) | (rde_q == hz.RA2D));
    pc_pend  = (hz.ValidD & hz.PCSrcD) | (ve_q & pcse_q) | (vm_q & pcsm_q);
    stall_d  = 1'b0;
    stall_f  = 1'b0;
    flush_e  = 1'b0;
    flush_d  = 1'b0;
    if (!reset) begin
      stall_d = ld_stall & ~hz.BranchTakenE;
      stall_f = (ld_stall | pc_pend) & ~hz.BranchTakenE;
      flush_e = ld_stall | hz.BranchTakenE;
      flush_d = pc_pend | (vw_q & pcsw_q) | hz.BranchTakenE;
    end
  end

  // Pipe advance: W<=M, M<=E, E takes D unless a bubble is inserted; counters saturate
  always_comb begin
    vw_d   = vm_q;
    rdw_d  = rdm_q;
    rww_d  = rwm_q;
    pcsw_d = pcsm_q;
    vm_d   = ve_q;
    rdm_d  = rde_q;
    rwm_d  = rwe_q;
    pcsm_d = pcse_q;
    ve_d   = 1'b0;
    ra1e_d = 4'd0;
    ra2e_d = 4'd0;
    rde_d  = 4'd0;
    rwe_d  = 1'b0;
    mtre_d = 1'b0;
    pcse_d = 1'b0;
    if (!(flush_e || stall_d)) begin
      ve_d   = hz.ValidD;
      ra1e_d = hz.RA1D;
      ra2e_d = hz.RA2D;
      rde_d  = hz.RdD;
      rwe_d  = hz.RegWriteD;
      mtre_d = hz.MemtoRegD;
      pcse_d = hz.PCSrcD;
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_e && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops every pending hazard at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ve_q        <= 1'b0;
      ra1e_q      <= 4'd0;
      ra2e_q      <= 4'd0;
      rde_q       <= 4'd0;
      rwe_q       <= 1'b0;
      mtre_q      <= 1'b0;
      pcse_q      <= 1'b0;
      vm_q        <= 1'b0;
      rdm_q       <= 4'd0;
      rwm_q       <= 1'b0;
      pcsm_q      <= 1'b0;
      vw_q        <= 1'b0;
      rdw_q       <= 4'd0;
      rww_q       <= 1'b0;
      pcsw_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ve_q        <= ve_d;
      ra1e_q      <= ra1e_d;
      ra2e_q      <= ra2e_d;
      rde_q       <= rde_d;
      rwe_q       <= rwe_d;
      mtre_q      <= mtre_d;
      pcse_q      <= pcse_d;
      vm_q        <= vm_d;
      rdm_q       <= rdm_d;
      rwm_q       <= rwm_d;
      pcsm_q      <= pcsm_d;
      vw_q        <= vw_d;
      rdw_q       <= rdw_d;
      rww_q       <= rww_d;
      pcsw_q      <= pcsw_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
endmodule
